// File: rtl/cycpuf_ctrl_pkg.sv
// rtl/cycpuf_ctrl_pkg.sv - shared types and defaults for the cyclic BPUF evaluation controller
package cycpuf_ctrl_pkg;

    localparam int DEF_WIDTH      = 15;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_NUM_EVAL   = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        VOTE,
        OUT
    } state_t;

    // Width of a per-bit ones counter able to hold 0..num_eval
    function automatic int vote_cnt_width(input int num_eval);
        return (num_eval < 1) ? 1 : $clog2(num_eval + 1);
    endfunction

endpackage

// File: rtl/cycpuf_bit_vote.sv
// rtl/cycpuf_bit_vote.sv - per-bit ones counter with majority output; unanimity flag under CYCPUF_STABILITY_EN
module cycpuf_bit_vote #(
    parameter int NUM_EVAL = 5,
    parameter int CNT_W    = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc_en,
    input  logic i_bit,
`ifdef CYCPUF_STABILITY_EN
    output logic o_unstable,
`endif
    output logic o_major
);

    logic [CNT_W-1:0] r_ones;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ones <= '0;
        end else if (i_clr) begin
            r_ones <= '0;
        end else if (i_inc_en && i_bit) begin
            r_ones <= r_ones + CNT_W'(1);
        end
    end

    assign o_major = (r_ones > CNT_W'(NUM_EVAL / 2));

`ifdef CYCPUF_STABILITY_EN
    assign o_unstable = (r_ones != '0) && (r_ones < CNT_W'(NUM_EVAL));
`endif

endmodule

// File: rtl/cycpuf_eval_ctrl.sv
// rtl/cycpuf_eval_ctrl.sv - challenge/settle/sample/vote controller for the BPUF array; CYCPUF_STABILITY_EN adds rsp_unstable
module cycpuf_eval_ctrl
    import cycpuf_ctrl_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int NUM_EVAL   = DEF_NUM_EVAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chal_valid,
    output logic             chal_ready,
    input  logic [WIDTH-1:0] chal_data,
    output logic [WIDTH-1:0] puf_chal,
    input  logic [WIDTH-1:0] puf_resp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef CYCPUF_STABILITY_EN
    output logic [WIDTH-1:0] rsp_unstable,
`endif
    output logic             busy
);

    localparam int VCNT_W  = vote_cnt_width(NUM_EVAL);
    localparam int CYC_MAX = (SETTLE_CYC > NUM_EVAL) ? SETTLE_CYC : NUM_EVAL;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    if ((NUM_EVAL < 1) || ((NUM_EVAL % 2) == 0) || (SETTLE_CYC < 1)) begin : g_bad_param
        $error("cycpuf_eval_ctrl: NUM_EVAL must be odd and >= 1, SETTLE_CYC must be >= 1");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CYC_W-1:0]   r_cyc;
    logic [WIDTH-1:0]   r_puf_chal;
    logic [WIDTH-1:0]   r_rsp_data;
    logic               r_rsp_valid;
    logic               w_chal_fire;
    logic               w_clr;
    logic               w_inc;
    logic [WIDTH-1:0]   w_major;
`ifdef CYCPUF_STABILITY_EN
    logic [WIDTH-1:0]   r_rsp_unstable;
    logic [WIDTH-1:0]   w_unstable;
`endif

    assign chal_ready  = rst_n && (r_state == IDLE);
    assign w_chal_fire = chal_valid && chal_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_chal_fire) begin
                    w_state_nxt = SETTLE;
                    w_clr       = 1'b1;
                end
            end
            SETTLE: begin
                if (r_cyc == '0) begin
                    w_state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                w_inc = 1'b1;
                if (r_cyc == '0) begin
                    w_state_nxt = VOTE;
                end
            end
            VOTE: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // r_cyc counts down the remaining cycles of SETTLE, then of SAMPLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc       <= '0;
            r_puf_chal  <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_chal_fire) begin
                        r_puf_chal <= chal_data;
                        r_cyc      <= CYC_W'(SETTLE_CYC - 1);
                    end
                end
                SETTLE: begin
                    if (r_cyc == '0) begin
                        r_cyc <= CYC_W'(NUM_EVAL - 1);
                    end else begin
                        r_cyc <= r_cyc - CYC_W'(1);
                    end
                end
                SAMPLE: begin
                    if (r_cyc != '0) begin
                        r_cyc <= r_cyc - CYC_W'(1);
                    end
                end
                VOTE: begin
                    r_rsp_data  <= w_major;
                    r_rsp_valid <= 1'b1;
                end
                OUT: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef CYCPUF_STABILITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_unstable <= '0;
        end else if (r_state == VOTE) begin
            r_rsp_unstable <= w_unstable;
        end
    end

    assign rsp_unstable = r_rsp_unstable;
`endif

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        cycpuf_bit_vote #(
            .NUM_EVAL (NUM_EVAL),
            .CNT_W    (VCNT_W)
        ) u_vote (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_clr      (w_clr),
            .i_inc_en   (w_inc),
            .i_bit      (puf_resp[gi]),
`ifdef CYCPUF_STABILITY_EN
            .o_unstable (w_unstable[gi]),
`endif
            .o_major    (w_major[gi])
        );
    end

    assign puf_chal  = r_puf_chal;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign busy      = (r_state != IDLE);

endmodule
